// File: rtl/hood_mode_fsm.sv
// hood_mode_fsm: mode sequencer for the range hood.
// Turns one-cycle button pulses and a 1 Hz strobe into the mode code used
// by the fan/timing datapath and display. Handles power on/off, gear
// selection, the one-shot hurricane (gear 3) countdown, the timed self-clean
// cycle and the standby idle auto-off.
//
// Ports:
//   clk             system clock
//   rst             synchronous reset, active-high
//   tick_1hz        one-cycle strobe, once per second
//   power_btn       power button pulse
//   gear1_btn       gear 1 button pulse
//   gear2_btn       gear 2 button pulse
//   gear3_btn       gear 3 (hurricane) button pulse
//   menu_btn        menu button pulse
//   clean_btn       self-clean button pulse
//   mode_state      000 STANDBY, 001 GEAR1, 010 GEAR2, 011 GEAR3, 100 CLEAN, 111 OFF
//   countdown_sec   remaining ticks in GEAR3/CLEAN, else 0
//   hurricane_avail gear 3 may still be entered this power session
//   menu_latched    menu pressed during the current GEAR3 run
//   clean_done      one-cycle pulse when CLEAN completes
module hood_mode_fsm #(
   parameter int unsigned HURRICANE_SEC = 60,
   parameter int unsigned CLEAN_SEC     = 180,
   parameter int unsigned IDLE_SEC      = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       power_btn,
   input  logic       gear1_btn,
   input  logic       gear2_btn,
   input  logic       gear3_btn,
   input  logic       menu_btn,
   input  logic       clean_btn,
   output logic [2:0] mode_state,
   output logic [7:0] countdown_sec,
   output logic       hurricane_avail,
   output logic       menu_latched,
   output logic       clean_done
);

   typedef enum logic [2:0] {
      ST_STANDBY = 3'b000,
      ST_GEAR1   = 3'b001,
      ST_GEAR2   = 3'b010,
      ST_GEAR3   = 3'b011,
      ST_CLEAN   = 3'b100,
      ST_OFF     = 3'b111
   } mode_t;

   localparam logic [7:0] HURRICANE_LOAD = 8'(HURRICANE_SEC);
   localparam logic [7:0] CLEAN_LOAD     = 8'(CLEAN_SEC);
   // Idle count value at which the next tick powers the hood off.
   localparam logic [7:0] IDLE_LAST      = 8'(IDLE_SEC - 1);

   mode_t      state;
   logic [7:0] idle_cnt;
   logic       any_btn;

   assign any_btn    = power_btn | gear1_btn | gear2_btn | gear3_btn |
                       menu_btn  | clean_btn;
   assign mode_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_OFF;
         countdown_sec   <= '0;
         hurricane_avail <= 1'b1;
         menu_latched    <= 1'b0;
         clean_done      <= 1'b0;
         idle_cnt        <= '0;
      end else begin
         clean_done <= 1'b0;
         case (state)
            ST_OFF: begin
               idle_cnt <= '0;
               if (power_btn) begin
                  state           <= ST_STANDBY;
                  hurricane_avail <= 1'b1;
               end
            end

            ST_STANDBY: begin
               // Any pulse (menu included) is activity; a tick alone counts.
               if (any_btn) begin
                  idle_cnt <= '0;
               end else if (tick_1hz) begin
                  if (idle_cnt >= IDLE_LAST) begin
                     state    <= ST_OFF;
                     idle_cnt <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + 8'd1;
                  end
               end
               // menu is not a transition here, so it never masks lower buttons.
               if (power_btn) begin
                  state <= ST_OFF;
               end else if (clean_btn) begin
                  state         <= ST_CLEAN;
                  countdown_sec <= CLEAN_LOAD;
               end else if (gear3_btn && hurricane_avail) begin
                  state           <= ST_GEAR3;
                  countdown_sec   <= HURRICANE_LOAD;
                  hurricane_avail <= 1'b0;
                  menu_latched    <= 1'b0;
               end else if (gear2_btn) begin
                  state <= ST_GEAR2;
               end else if (gear1_btn) begin
                  state <= ST_GEAR1;
               end
            end

            ST_GEAR1, ST_GEAR2: begin
               idle_cnt <= '0;
               if (menu_btn) begin
                  state <= ST_STANDBY;
               end else if (gear3_btn && hurricane_avail) begin
                  state           <= ST_GEAR3;
                  countdown_sec   <= HURRICANE_LOAD;
                  hurricane_avail <= 1'b0;
                  menu_latched    <= 1'b0;
               end else if (gear2_btn) begin
                  state <= ST_GEAR2;
               end else if (gear1_btn) begin
                  state <= ST_GEAR1;
               end
            end

            ST_GEAR3: begin
               idle_cnt <= '0;
               if (menu_btn) menu_latched <= 1'b1;
               if (tick_1hz) begin
                  if (countdown_sec <= 8'd1) begin
                     // A menu press on the final tick still selects STANDBY.
                     countdown_sec <= '0;
                     menu_latched  <= 1'b0;
                     state         <= (menu_latched || menu_btn) ? ST_STANDBY : ST_GEAR2;
                  end else begin
                     countdown_sec <= countdown_sec - 8'd1;
                  end
               end
            end

            ST_CLEAN: begin
               idle_cnt <= '0;
               if (tick_1hz) begin
                  if (countdown_sec <= 8'd1) begin
                     countdown_sec <= '0;
                     state         <= ST_STANDBY;
                     clean_done    <= 1'b1;
                  end else begin
                     countdown_sec <= countdown_sec - 8'd1;
                  end
               end
            end

            default: begin
               state         <= ST_OFF;
               countdown_sec <= '0;
               menu_latched  <= 1'b0;
               idle_cnt      <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hood_mode_fsm.sv
// tb_hood_mode_fsm: directed-vector bench for hood_mode_fsm with a
// scoreboard queue of expected output snapshots and a negedge monitor.
module tb_hood_mode_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz;
   logic       power_btn, gear1_btn, gear2_btn, gear3_btn, menu_btn, clean_btn;
   logic [2:0] mode_state;
   logic [7:0] countdown_sec;
   logic       hurricane_avail, menu_latched, clean_done;

   always #5 clk = ~clk;

   hood_mode_fsm #(
      .HURRICANE_SEC(60),
      .CLEAN_SEC    (180),
      .IDLE_SEC     (60)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .tick_1hz       (tick_1hz),
      .power_btn      (power_btn),
      .gear1_btn      (gear1_btn),
      .gear2_btn      (gear2_btn),
      .gear3_btn      (gear3_btn),
      .menu_btn       (menu_btn),
      .clean_btn      (clean_btn),
      .mode_state     (mode_state),
      .countdown_sec  (countdown_sec),
      .hurricane_avail(hurricane_avail),
      .menu_latched   (menu_latched),
      .clean_done     (clean_done)
   );

   // Button vector order: {power, menu, clean, gear3, gear2, gear1}
   localparam logic [5:0] B_NONE  = 6'b000000;
   localparam logic [5:0] B_PWR   = 6'b100000;
   localparam logic [5:0] B_MENU  = 6'b010000;
   localparam logic [5:0] B_CLEAN = 6'b001000;
   localparam logic [5:0] B_G3    = 6'b000100;
   localparam logic [5:0] B_G2    = 6'b000010;
   localparam logic [5:0] B_G1    = 6'b000001;

   localparam logic [2:0] M_STB = 3'b000;
   localparam logic [2:0] M_G1  = 3'b001;
   localparam logic [2:0] M_G2  = 3'b010;
   localparam logic [2:0] M_G3  = 3'b011;
   localparam logic [2:0] M_CLN = 3'b100;
   localparam logic [2:0] M_OFF = 3'b111;

   typedef struct packed {
      logic [2:0] mode;
      logic [7:0] cd;
      logic       avail;
      logic       ml;
      logic       done;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   // Drive one cycle of stimulus; returns at posedge+1 with inputs cleared.
   task automatic step(input logic [5:0] b, input logic tk);
      {power_btn, menu_btn, clean_btn, gear3_btn, gear2_btn, gear1_btn} = b;
      tick_1hz = tk;
      @(posedge clk);
      #1;
      {power_btn, menu_btn, clean_btn, gear3_btn, gear2_btn, gear1_btn} = B_NONE;
      tick_1hz = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(B_NONE, 1'b1);
   endtask

   task automatic exp_push(input string nm, input logic [2:0] m, input int c,
                           input logic a, input logic ml, input logic d);
      exp_t e;
      e.mode  = m;
      e.cd    = 8'(c);
      e.avail = a;
      e.ml    = ml;
      e.done  = d;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: compares every pending expectation against the outputs
   // sampled half a cycle after the edge that produced them.
   exp_t  mon_e;
   string mon_nm;
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         mon_e  = exp_q.pop_front();
         mon_nm = name_q.pop_front();
         checks++;
         if (mode_state !== mon_e.mode || countdown_sec !== mon_e.cd ||
             hurricane_avail !== mon_e.avail || menu_latched !== mon_e.ml ||
             clean_done !== mon_e.done) begin
            errors++;
            $display("FAIL %s: got mode=%b cd=%0d avail=%b ml=%b done=%b, expected mode=%b cd=%0d avail=%b ml=%b done=%b",
                     mon_nm, mode_state, countdown_sec, hurricane_avail, menu_latched, clean_done,
                     mon_e.mode, mon_e.cd, mon_e.avail, mon_e.ml, mon_e.done);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      tick_1hz = 1'b0;
      {power_btn, menu_btn, clean_btn, gear3_btn, gear2_btn, gear1_btn} = B_NONE;
      @(posedge clk);
      #1;
      exp_push("reset", M_OFF, 0, 1, 0, 0);
      rst = 1'b0;

      // Power and gears
      step(B_PWR,  1'b0); exp_push("power_on",   M_STB, 0, 1, 0, 0);
      step(B_G1,   1'b0); exp_push("gear1",      M_G1,  0, 1, 0, 0);
      step(B_G2,   1'b0); exp_push("gear2",      M_G2,  0, 1, 0, 0);
      step(B_MENU, 1'b0); exp_push("menu_stb",   M_STB, 0, 1, 0, 0);
      step(B_PWR,  1'b0); exp_push("power_off",  M_OFF, 0, 1, 0, 0);

      // Hurricane returning to GEAR2; entry tick ignored, power ignored
      step(B_PWR,  1'b0); exp_push("power_on2",  M_STB, 0, 1, 0, 0);
      step(B_G1,   1'b0); exp_push("gear1_b",    M_G1,  0, 1, 0, 0);
      step(B_G3,   1'b1); exp_push("g3_entry",   M_G3, 60, 0, 0, 0);
      step(B_PWR,  1'b0); exp_push("g3_pwr_ign", M_G3, 60, 0, 0, 0);
      ticks(59);          exp_push("g3_cd1",     M_G3,  1, 0, 0, 0);
      ticks(1);           exp_push("g3_to_g2",   M_G2,  0, 0, 0, 0);
      step(B_G3,   1'b0); exp_push("g3_spent",   M_G2,  0, 0, 0, 0);
      step(B_G3 | B_G1, 1'b0); exp_push("g3_nomask", M_G1, 0, 0, 0, 0);

      // Re-arm, priority, hurricane returning to STANDBY
      step(B_MENU, 1'b0); exp_push("menu_stb2",  M_STB, 0, 0, 0, 0);
      step(B_PWR,  1'b0); exp_push("off_noarm",  M_OFF, 0, 0, 0, 0);
      step(B_PWR,  1'b0); exp_push("rearm",      M_STB, 0, 1, 0, 0);
      step(B_G1 | B_G3, 1'b0); exp_push("prio_g3", M_G3, 60, 0, 0, 0);
      ticks(30);          exp_push("g3_cd30",    M_G3, 30, 0, 0, 0);
      step(B_MENU, 1'b0); exp_push("menu_latch", M_G3, 30, 0, 1, 0);
      ticks(29);          exp_push("g3_cd1_ml",  M_G3,  1, 0, 1, 0);
      ticks(1);           exp_push("g3_to_stb",  M_STB, 0, 0, 0, 0);
      step(B_PWR | B_CLEAN, 1'b0); exp_push("prio_pwr", M_OFF, 0, 0, 0, 0);
      step(B_PWR,  1'b0); exp_push("rearm2",     M_STB, 0, 1, 0, 0);

      // Clean cycle and idle auto-off
      step(B_CLEAN, 1'b0); exp_push("clean_in",  M_CLN, 180, 1, 0, 0);
      ticks(179);         exp_push("clean_cd1",  M_CLN,  1, 1, 0, 0);
      ticks(1);           exp_push("clean_done", M_STB,  0, 1, 0, 1);
      step(B_NONE, 1'b0); exp_push("done_pulse", M_STB,  0, 1, 0, 0);
      ticks(59);          exp_push("idle_59",    M_STB,  0, 1, 0, 0);
      step(B_MENU, 1'b0); exp_push("idle_clear", M_STB,  0, 1, 0, 0);
      ticks(59);          exp_push("idle_59b",   M_STB,  0, 1, 0, 0);
      ticks(1);           exp_push("idle_off",   M_OFF,  0, 1, 0, 0);

      // Reset mid-countdown
      step(B_PWR,  1'b0); exp_push("power_on3",  M_STB, 0, 1, 0, 0);
      step(B_G3,   1'b0); exp_push("g3_entry3",  M_G3, 60, 0, 0, 0);
      ticks(18);          exp_push("g3_cd42",    M_G3, 42, 0, 0, 0);
      rst = 1'b1;
      step(B_NONE, 1'b1); exp_push("rst_mid",    M_OFF, 0, 1, 0, 0);
      rst = 1'b0;
      step(B_PWR,  1'b0); exp_push("after_rst",  M_STB, 0, 1, 0, 0);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
